// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: stall/branch control in, instruction memory port, and the
// instruction/PC/valid bundle handed to the IF/ID register.
interface instr_fetch_unit_if;
  logic        StallIN;
  logic        BranchTakenIN;
  logic [15:0] BranchTargetIN;
  logic [15:0] ImemAddrOUT;
  logic [31:0] ImemDataIN;
  logic [31:0] InstructionOUT;
  logic [15:0] PcOUT;
  logic        ValidOUT;
  logic        HaltedOUT;

  // Fetch unit side
  modport master (
    input  StallIN, BranchTakenIN, BranchTargetIN, ImemDataIN,
    output ImemAddrOUT, InstructionOUT, PcOUT, ValidOUT, HaltedOUT
  );

  // Pipeline / memory side
  modport slave (
    output StallIN, BranchTakenIN, BranchTargetIN, ImemDataIN,
    input  ImemAddrOUT, InstructionOUT, PcOUT, ValidOUT, HaltedOUT
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a synchronous instruction
// memory (1-cycle read latency) and presents one instruction per cycle with
// its PC and a valid flag. Supports stall replay, branch redirect with a
// single bubble, and a halt opcode that freezes fetch until reset.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [4:0]  HALT_OPCODE = 5'b11111,
  parameter logic [31:0] NOP_WORD    = 32'h00000000
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.master bus
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [15:0] pc;       // next address to issue
  logic [15:0] ifPc;     // address whose data is on ImemDataIN
  logic        ifValid;  // in-flight address is on-path
  logic [0:0]  state;

  logic running;
  logic validNow;
  logic haltNow;

  // Output validity and halt detection for the word currently on the bus
  always_comb begin
    running  = (state == RUN);
    validNow = ifValid & ~bus.BranchTakenIN & running;
    haltNow  = validNow & ~bus.StallIN &
               (bus.ImemDataIN[31:27] == HALT_OPCODE);
  end

  // Downstream-facing outputs
  always_comb begin
    bus.ValidOUT       = validNow;
    bus.InstructionOUT = validNow ? bus.ImemDataIN : NOP_WORD;
    bus.PcOUT          = ifPc;
    bus.HaltedOUT      = ~running;
  end

  // Memory address select: a stall re-issues the in-flight address so the
  // same data comes back next cycle, which is what holds the output steady.
  always_comb begin
    if (!running) begin
      bus.ImemAddrOUT = pc;
    end else if (bus.BranchTakenIN) begin
      bus.ImemAddrOUT = bus.BranchTargetIN;
    end else if (bus.StallIN) begin
      bus.ImemAddrOUT = ifPc;
    end else begin
      bus.ImemAddrOUT = pc;
    end
  end

  // PC / in-flight tracking and RUN/HALTED state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      ifPc    <= RESET_PC;
      ifValid <= 1'b0;
      state   <= RUN;
    end else if (running) begin
      if (bus.BranchTakenIN) begin
        ifPc    <= bus.BranchTargetIN;
        ifValid <= 1'b1;
        pc      <= bus.BranchTargetIN + 16'd1;
      end else if (bus.StallIN) begin
        pc      <= pc;
        ifPc    <= ifPc;
        ifValid <= ifValid;
      end else if (haltNow) begin
        // Halt word is accepted this cycle; fetch freezes with pc held.
        ifValid <= 1'b0;
        state   <= HALTED;
      end else begin
        ifPc    <= pc;
        ifValid <= 1'b1;
        pc      <= pc + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (RESET_PC 0 and FFFE) share the
// control stimulus; each has its own memory. A queue-free "what is shown"
// model predicts outputs every cycle; directed cases pin literal values.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [15:0] target = 16'h0000;

  int checks = 0;
  int errors = 0;

  logic        haltEn   [2] = '{1'b0, 1'b0};
  logic [15:0] haltAddr [2] = '{16'h0000, 16'h0000};
  logic [15:0] rstPc    [2] = '{16'h0000, 16'hFFFE};

  always #5 clk = ~clk;

  instr_fetch_unit_if if0 ();
  instr_fetch_unit_if if1 ();

  instr_fetch_unit #(.RESET_PC(16'h0000), .HALT_OPCODE(5'b11111), .NOP_WORD(32'h00000000))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  instr_fetch_unit #(.RESET_PC(16'hFFFE), .HALT_OPCODE(5'b11111), .NOP_WORD(32'h00000000))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

  assign if0.StallIN = stall;
  assign if0.BranchTakenIN = branch;
  assign if0.BranchTargetIN = target;
  assign if1.StallIN = stall;
  assign if1.BranchTakenIN = branch;
  assign if1.BranchTargetIN = target;

  function automatic logic [31:0] memFn(int k, logic [15:0] a);
    if (haltEn[k] && a == haltAddr[k]) return 32'hF800_0000;
    return 32'h1000_0000 + {16'h0000, a};
  endfunction

  function automatic logic [4:0] opOf(int k, logic [15:0] a);
    logic [31:0] w;
    w = memFn(k, a);
    return w[31:27];
  endfunction

  // Synchronous instruction memories
  logic [31:0] memQ0, memQ1;
  always @(posedge clk) begin
    memQ0 <= memFn(0, if0.ImemAddrOUT);
    memQ1 <= memFn(1, if1.ImemAddrOUT);
  end
  assign if0.ImemDataIN = memQ0;
  assign if1.ImemDataIN = memQ1;

  logic [15:0] gAddr [2];
  logic [31:0] gInstr[2];
  logic [15:0] gPc   [2];
  logic        gValid[2];
  logic        gHalt [2];
  assign gAddr[0] = if0.ImemAddrOUT;  assign gAddr[1] = if1.ImemAddrOUT;
  assign gInstr[0] = if0.InstructionOUT; assign gInstr[1] = if1.InstructionOUT;
  assign gPc[0] = if0.PcOUT;          assign gPc[1] = if1.PcOUT;
  assign gValid[0] = if0.ValidOUT;    assign gValid[1] = if1.ValidOUT;
  assign gHalt[0] = if0.HaltedOUT;    assign gHalt[1] = if1.HaltedOUT;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: which address is on display, whether it is real, the next
  // address to fetch, and whether fetch has halted.
  logic        modelOn = 1'b0;
  logic [15:0] mShowPc [2];
  logic        mShowVal[2];
  logic [15:0] mNextPc [2];
  logic        mHalted [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mShowPc[k]  <= rstPc[k];
        mNextPc[k]  <= rstPc[k];
        mShowVal[k] <= 1'b0;
        mHalted[k]  <= 1'b0;
      end else if (modelOn && !mHalted[k]) begin
        if (branch) begin
          mShowPc[k]  <= target;
          mNextPc[k]  <= target + 16'd1;
          mShowVal[k] <= 1'b1;
        end else if (stall) begin
          mShowPc[k] <= mShowPc[k];
        end else if (mShowVal[k] && opOf(k, mShowPc[k]) == 5'b11111) begin
          mHalted[k]  <= 1'b1;
          mShowVal[k] <= 1'b0;
        end else begin
          mShowPc[k]  <= mNextPc[k];
          mNextPc[k]  <= mNextPc[k] + 16'd1;
          mShowVal[k] <= 1'b1;
        end
      end
    end
    if (!rst_n) modelOn <= 1'b1;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (modelOn) begin
      for (int k = 0; k < 2; k++) begin
        logic        eValid;
        logic [15:0] eAddr;
        eValid = mShowVal[k] && !branch && !mHalted[k];
        if (mHalted[k])  eAddr = mNextPc[k];
        else if (branch) eAddr = target;
        else if (stall)  eAddr = mShowPc[k];
        else             eAddr = mNextPc[k];
        chk($sformatf("model valid[%0d]", k), {31'd0, gValid[k]}, {31'd0, eValid});
        chk($sformatf("model instr[%0d]", k), gInstr[k], eValid ? memFn(k, mShowPc[k]) : 32'h0);
        chk($sformatf("model pc[%0d]", k), {16'd0, gPc[k]}, {16'd0, mShowPc[k]});
        chk($sformatf("model addr[%0d]", k), {16'd0, gAddr[k]}, {16'd0, eAddr});
        chk($sformatf("model halted[%0d]", k), {31'd0, gHalt[k]}, {31'd0, mHalted[k]});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Two-cycle reset; memory contents change only while reset is applied
  task automatic doReset(logic en0, logic [15:0] a0);
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0;
    tick;
    haltEn[0] = en0; haltAddr[0] = a0; haltEn[1] = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    tick; tick; #1;
    chk("rst addr0", {16'd0, if0.ImemAddrOUT}, 32'h0000_0000);
    chk("rst addr1", {16'd0, if1.ImemAddrOUT}, 32'h0000_FFFE);
    chk("rst instr", if0.InstructionOUT, 32'h0000_0000);
    chk("rst pc1", {16'd0, if1.PcOUT}, 32'h0000_FFFE);
    chk("rst valid", {31'd0, if0.ValidOUT}, 32'd0);
    chk("rst halted", {31'd0, if0.HaltedOUT}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("cyc0 valid", {31'd0, if0.ValidOUT}, 32'd0);
    chk("cyc0 addr", {16'd0, if0.ImemAddrOUT}, 32'd0);

    // Sequential fetch and wrap-around
    for (int n = 1; n <= 4; n++) begin
      logic [15:0] wp;
      tick; #1;
      wp = 16'hFFFE + 16'(n - 1);
      chk("wrap pc", {16'd0, if1.PcOUT}, {16'd0, wp});
      chk("wrap valid", {31'd0, if1.ValidOUT}, 32'd1);
      if (n == 1) begin
        chk("seq c1 pc", {16'd0, if0.PcOUT}, 32'd0);
        chk("seq c1 instr", if0.InstructionOUT, 32'h1000_0000);
        chk("seq c1 valid", {31'd0, if0.ValidOUT}, 32'd1);
      end
    end
    chk("seq c4 pc", {16'd0, if0.PcOUT}, 32'd3);
    chk("seq c4 instr", if0.InstructionOUT, 32'h1000_0003);

    // Stall at PcOUT=2 for three cycles
    doReset(1'b0, 16'h0);
    tick; tick; tick;
    stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) tick;
      #1;
      chk("stall pc", {16'd0, if0.PcOUT}, 32'd2);
      chk("stall instr", if0.InstructionOUT, 32'h1000_0002);
      chk("stall valid", {31'd0, if0.ValidOUT}, 32'd1);
      chk("stall addr", {16'd0, if0.ImemAddrOUT}, 32'd2);
    end
    tick; stall = 1'b0; #1;
    chk("stall drop pc", {16'd0, if0.PcOUT}, 32'd2);
    tick; #1;
    chk("post stall pc", {16'd0, if0.PcOUT}, 32'd3);

    // Branch at PcOUT=5 with stall in the same cycle
    tick; tick; #1;
    chk("pre branch pc", {16'd0, if0.PcOUT}, 32'd5);
    branch = 1'b1; stall = 1'b1; target = 16'h0040; #1;
    chk("br valid", {31'd0, if0.ValidOUT}, 32'd0);
    chk("br instr", if0.InstructionOUT, 32'h0000_0000);
    chk("br addr", {16'd0, if0.ImemAddrOUT}, 32'h0000_0040);
    tick; branch = 1'b0; stall = 1'b0; #1;
    chk("br tgt pc", {16'd0, if0.PcOUT}, 32'h0000_0040);
    chk("br tgt valid", {31'd0, if0.ValidOUT}, 32'd1);
    chk("br tgt instr", if0.InstructionOUT, 32'h1000_0040);
    tick; #1;
    chk("br tgt+1 pc", {16'd0, if0.PcOUT}, 32'h0000_0041);

    // Halt at address 3
    doReset(1'b1, 16'h0003);
    tick; tick; tick; tick; #1;
    chk("halt word pc", {16'd0, if0.PcOUT}, 32'd3);
    chk("halt word instr", if0.InstructionOUT, 32'hF800_0000);
    chk("halt word valid", {31'd0, if0.ValidOUT}, 32'd1);
    chk("halt not yet", {31'd0, if0.HaltedOUT}, 32'd0);
    tick; #1;
    chk("halted", {31'd0, if0.HaltedOUT}, 32'd1);
    chk("halted valid", {31'd0, if0.ValidOUT}, 32'd0);
    branch = 1'b1; target = 16'h0010;
    tick; branch = 1'b0; #1;
    chk("halted after br", {31'd0, if0.HaltedOUT}, 32'd1);
    chk("halted br valid", {31'd0, if0.ValidOUT}, 32'd0);
    tick; #1;
    chk("halted br pc", {31'd0, if0.ValidOUT}, 32'd0);

    // Reset while stalled at PcOUT=7
    doReset(1'b0, 16'h0);
    for (int n = 0; n < 8; n++) tick;
    stall = 1'b1; #1;
    chk("pre rst pc", {16'd0, if0.PcOUT}, 32'd7);
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; #1;
    chk("mid rst valid", {31'd0, if0.ValidOUT}, 32'd0);
    chk("mid rst halted", {31'd0, if0.HaltedOUT}, 32'd0);
    chk("mid rst addr", {16'd0, if0.ImemAddrOUT}, 32'd0);
    stall = 1'b0;
    tick; #1;
    chk("mid rst pc", {16'd0, if0.PcOUT}, 32'd0);
    chk("mid rst valid1", {31'd0, if0.ValidOUT}, 32'd1);

    // Randomized traffic, checked by the model process
    for (int i = 0; i < 1500; i++) begin
      tick;
      if (!rst_n) begin
        haltEn[0]   = 1'($urandom_range(0, 1));
        haltEn[1]   = 1'($urandom_range(0, 1));
        haltAddr[0] = 16'($urandom_range(0, 40));
        haltAddr[1] = 16'($urandom_range(0, 40));
      end
      rst_n  = ($urandom_range(0, 39) != 0);
      stall  = ($urandom_range(0, 9) < 3);
      branch = ($urandom_range(0, 9) == 0);
      target = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 40));
    end
    tick; tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
